// File: rtl/led_pio_pkg.sv
// Shared constants for the LED PIO with hardware blink: register word
// addresses and the STATUS bit layout.
package led_pio_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_MASK     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd5;

    localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/led_pio_blink_prescaler.sv
// Blink phase generator: each phase lasts exactly `period` cycles; a period
// of zero parks the phase high, and restart resynchronises to phase 1.
module blink_prescaler #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] period,
    input  logic             restart,
    output logic             phase
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic             terminal;

    assign terminal = (cnt == (period - ONE));

    // restart is checked ahead of the terminal count so a PERIOD write
    // landing on the toggle cycle suppresses that toggle.
    always_ff @(posedge clk) begin
        if (reset || restart || (period == '0)) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (terminal) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + ONE;
        end
    end

endmodule

// File: rtl/led_pio_blink.sv
// Avalon-MM LED output PIO with set/clear aliases and per-bit blink masking
// driven by a programmable prescaler.
module led_pio_blink
    import led_pio_pkg::*;
#(
    parameter int               WIDTH          = 9,
    parameter int               CNT_W          = 26,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port
);

    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] blink_mask;
    logic [CNT_W-1:0] period;
    logic             phase;
    logic             wr;
    logic             restart;
    logic [WIDTH-1:0] wdata_w;
    logic             unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign restart      = wr && (address == ADDR_PERIOD);
    assign wdata_w      = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            data       <= RESET_VALUE;
            blink_mask <= '0;
            period     <= DEFAULT_PERIOD;
        end else if (wr) begin
            case (address)
                ADDR_DATA:     data       <= wdata_w;
                ADDR_MASK:     blink_mask <= wdata_w;
                ADDR_PERIOD:   period     <= writedata[CNT_W-1:0];
                ADDR_OUTSET:   data       <= data | wdata_w;
                ADDR_OUTCLEAR: data       <= data & ~wdata_w;
                default:       ;
            endcase
        end
    end

    blink_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .period  (period),
        .restart (restart),
        .phase   (phase)
    );

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[WIDTH-1:0]      = data;
            ADDR_MASK:   readdata[WIDTH-1:0]      = blink_mask;
            ADDR_PERIOD: readdata[CNT_W-1:0]      = period;
            ADDR_STATUS: readdata[STATUS_PHASE_BIT] = phase;
            default:     readdata                 = '0;
        endcase
    end

    // Masked bits are blanked only during phase 0.
    assign out_port = data & ~(blink_mask & {WIDTH{~phase}});

endmodule

// File: tb/tb_led_pio_blink.sv
// Directed bench for led_pio_blink: register map, set/clear aliases,
// blink timing, PERIOD resync and reset mid-blink.
module tb_led_pio_blink;
    import led_pio_pkg::*;

    localparam int         WIDTH = 9;
    localparam int         CNT_W = 26;
    localparam logic [8:0] RV    = 9'h155;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [WIDTH-1:0]  out_port;

    int tests_run = 0;
    int tests_failed = 0;

    led_pio_blink #(
        .WIDTH          (WIDTH),
        .CNT_W          (CNT_W),
        .RESET_VALUE    (RV),
        .DEFAULT_PERIOD (26'd0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write commits on the next posedge and the
    // task returns at the following negedge.
    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("reset_out", 32'(out_port), 32'h155);
        rd_chk("reset_data", ADDR_DATA, 32'h155);
        rd_chk("reset_mask", ADDR_MASK, 32'h0);
        rd_chk("reset_period", ADDR_PERIOD, 32'h0);
        rd_chk("reset_status", ADDR_STATUS, 32'h1);

        bus_write(ADDR_DATA, 32'hFFFF_FFFF);
        chk("data_all_out", 32'(out_port), 32'h1FF);
        rd_chk("data_all_rd", ADDR_DATA, 32'h0000_01FF);

        // write strobe without chipselect
        address   = ADDR_DATA;
        writedata = 32'h0;
        write_n   = 1'b0;
        @(negedge clk);
        write_n   = 1'b1;
        chk("nocs_out", 32'(out_port), 32'h1FF);

        bus_write(3'd6, 32'h0);
        chk("rsvd_out", 32'(out_port), 32'h1FF);
        rd_chk("rsvd_rd6", 3'd6, 32'h0);
        rd_chk("rsvd_rd7", 3'd7, 32'h0);

        bus_write(ADDR_PERIOD, 32'hFFFF_FFFF);
        rd_chk("period_wide", ADDR_PERIOD, 32'h03FF_FFFF);
        bus_write(ADDR_PERIOD, 32'h0);

        bus_write(ADDR_DATA, 32'h0F0);
        bus_write(ADDR_OUTSET, 32'h003);
        rd_chk("outset", ADDR_DATA, 32'h0F3);
        bus_write(ADDR_OUTCLEAR, 32'h030);
        rd_chk("outclear", ADDR_DATA, 32'h0C3);
        chk("outclear_out", 32'(out_port), 32'h0C3);
        rd_chk("outset_rd", ADDR_OUTSET, 32'h0);
        rd_chk("outclear_rd", ADDR_OUTCLEAR, 32'h0);

        // blink, period 4
        bus_write(ADDR_DATA, 32'h1FF);
        bus_write(ADDR_MASK, 32'h00F);
        bus_write(ADDR_PERIOD, 32'd4);
        address = ADDR_STATUS;
        #1;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("blink4_out_%0d", i), 32'(out_port),
                ((i / 4) % 2 == 0) ? 32'h1FF : 32'h1F0);
            chk($sformatf("blink4_st_%0d", i), readdata,
                ((i / 4) % 2 == 0) ? 32'h1 : 32'h0);
            @(negedge clk);
            #1;
        end
        // now in phase 0
        chk("pre_p0_out", 32'(out_port), 32'h1F0);
        @(negedge clk);
        bus_write(ADDR_PERIOD, 32'd0);
        chk("p0_out", 32'(out_port), 32'h1FF);
        rd_chk("p0_status", ADDR_STATUS, 32'h1);
        repeat (3) @(negedge clk);
        chk("p0_hold", 32'(out_port), 32'h1FF);

        // period 1: toggle every cycle
        bus_write(ADDR_PERIOD, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("p1_out_%0d", i), 32'(out_port), (i % 2 == 0) ? 32'h1FF : 32'h1F0);
            @(negedge clk);
        end

        // rewrite PERIOD on the terminal-count cycle
        bus_write(ADDR_PERIOD, 32'd4);
        repeat (3) @(negedge clk);
        bus_write(ADDR_PERIOD, 32'd4);
        rd_chk("tc_status", ADDR_STATUS, 32'h1);
        chk("tc_out", 32'(out_port), 32'h1FF);
        repeat (3) @(negedge clk);
        #1;
        chk("tc_hold", readdata, 32'h1);
        @(negedge clk);
        #1;
        chk("tc_toggle", readdata, 32'h0);
        chk("tc_toggle_out", 32'(out_port), 32'h1F0);

        // reset during phase 0
        reset = 1'b1;
        @(negedge clk);
        chk("rst_out", 32'(out_port), 32'h155);
        rd_chk("rst_data", ADDR_DATA, 32'h155);
        rd_chk("rst_mask", ADDR_MASK, 32'h0);
        rd_chk("rst_period", ADDR_PERIOD, 32'h0);
        rd_chk("rst_status", ADDR_STATUS, 32'h1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_after", 32'(out_port), 32'h155);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
